// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - registered decode/control stage with load-use stall, redirect flush and multi-cycle sequencer
// Optional illegal-encoding trap: define CTRL_ILLEGAL_TRAP_EN.
module pipe_ctrl_unit #(
    parameter int REG_AW     = 5,
    parameter int MC_LATENCY = 4,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [2:0]            op,
    input  logic [2:0]            func3,
    input  logic [10:0]           func11,
    input  logic [REG_AW-1:0]     rs1,
    input  logic [REG_AW-1:0]     rs2,
    input  logic [REG_AW-1:0]     rd,
    input  logic                  ex_load,
    input  logic [REG_AW-1:0]     ex_rd,
    input  logic                  redirect,
    output logic                  ctrl_valid,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  jump,
    output logic                  jump_cond,
    output logic                  alu_src_op1,
    output logic                  alu_src_op2,
    output logic                  pc_target_src,
    output logic [2:0]            jump_cond_type,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            imm_src,
    output logic [1:0]            result_src,
    output logic                  mc_start,
    output logic [2:0]            mc_op,
    output logic                  stall,
    output logic                  illegal_instr
);
    localparam int CW = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;

    localparam logic [2:0] OP_A = 3'd0, OP_B = 3'd1, OP_C = 3'd2, OP_D = 3'd3;
    localparam logic [2:0] OP_E = 3'd4, OP_F = 3'd5, OP_G = 3'd6, OP_H = 3'd7;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic w_hz, w_is_e, w_illegal, w_idle_ok, w_issue, w_start, w_trap;
    logic w_unused;

    // rd is carried by the datapath pipeline; only func11[0] is meaningful here
    assign w_unused = &{1'b0, rd, func11[10:1]};

    assign w_hz = instr_valid & ex_load & (ex_rd != '0) &
                  ((ex_rd == rs1) | ((ex_rd == rs2) & ((op == OP_A) | (op == OP_C) | (op == OP_G))));
    assign w_is_e = (op == OP_E);

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign w_illegal = (op == OP_H) |
                       ((op == OP_D) & (func3 > 3'b010)) |
                       ((op == OP_F) & (func3 != 3'b000) & (func3 != 3'b010));
`else
    assign w_illegal = 1'b0;
`endif

    assign w_idle_ok = !redirect & (r_state == S_IDLE) & instr_valid & !w_hz;
    assign w_issue   = w_idle_ok & !w_illegal;
    assign w_start   = w_issue & w_is_e;
    assign w_trap    = w_idle_ok & w_illegal;

    // Decoded control bits before bubble gating
    logic                  w_dec_reg_write, w_dec_mem_write, w_dec_jump, w_dec_jump_cond;
    logic                  w_dec_src1, w_dec_src2, w_dec_pts;
    logic [ALU_CTRL_W-1:0] w_dec_alu;
    logic [3:0]            w_dec_imm;
    logic [1:0]            w_dec_res;

    always_comb begin
        w_dec_reg_write = (op[1:0] != 2'b10);
        w_dec_mem_write = (op == OP_C);
        w_dec_jump      = ((op == OP_D) | (op == OP_F)) & (func3 == 3'b010);
        w_dec_jump_cond = (op == OP_G);
        w_dec_src1      = (op != OP_D);
        w_dec_src2      = (op != OP_A) & (op != OP_G);
        w_dec_pts       = (op == OP_F);
        w_dec_alu       = '0;
        w_dec_imm       = 4'b0000;
        w_dec_res       = 2'b00;
        case (op)
            OP_A: w_dec_alu = ALU_CTRL_W'({func11[0], func3});
            OP_B: begin
                w_dec_alu = ALU_CTRL_W'({1'b0, func3});
                if ((func3 == 3'b101) || (func3 == 3'b110)) w_dec_imm = 4'b0001;
            end
            OP_C: w_dec_imm = 4'b0100;
            OP_D: begin
                w_dec_imm = (func3 == 3'b001) ? 4'b1110 : 4'b1100;
                if (func3 == 3'b010) w_dec_res = 2'b10;
            end
            OP_E: w_dec_alu = ALU_CTRL_W'({1'b1, func3});
            OP_F: if (func3 == 3'b000) w_dec_res = 2'b01;
            OP_G: begin
                w_dec_alu = ALU_CTRL_W'(4'd1);
                w_dec_imm = 4'b1000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (redirect) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = CW'(MC_LATENCY - 1);
                end
                S_BUSY: if (r_cnt == '0) w_state_nxt = S_IDLE;
                        else w_cnt_nxt = r_cnt - 1'b1;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; anything not issued becomes a bubble
    logic                  w_d_valid, w_d_rw, w_d_mw, w_d_j, w_d_jc, w_d_s1, w_d_s2, w_d_pts;
    logic [2:0]            w_d_jct, w_d_mc_op;
    logic [ALU_CTRL_W-1:0] w_d_alu;
    logic [3:0]            w_d_imm;
    logic [1:0]            w_d_res;

    always_comb begin
        // The OP_E slot carries its decode but is not valid: it retires via the multi-cycle unit
        w_d_valid = w_issue & !w_is_e;
        w_d_rw    = w_issue & w_dec_reg_write;
        w_d_mw    = w_issue & w_dec_mem_write;
        w_d_j     = w_issue & w_dec_jump;
        w_d_jc    = w_issue & w_dec_jump_cond;
        w_d_s1    = w_issue & w_dec_src1;
        w_d_s2    = w_issue & w_dec_src2;
        w_d_pts   = w_issue & w_dec_pts;
        w_d_jct   = w_issue ? func3 : 3'b000;
        w_d_alu   = w_issue ? w_dec_alu : '0;
        w_d_imm   = w_issue ? w_dec_imm : 4'b0000;
        w_d_res   = w_issue ? w_dec_res : 2'b00;
        w_d_mc_op = w_start ? func3 : 3'b000;
        stall     = rst_n & !redirect & ((r_state == S_BUSY) | w_hz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_valid     <= 1'b0;
            reg_write      <= 1'b0;
            mem_write      <= 1'b0;
            jump           <= 1'b0;
            jump_cond      <= 1'b0;
            alu_src_op1    <= 1'b0;
            alu_src_op2    <= 1'b0;
            pc_target_src  <= 1'b0;
            jump_cond_type <= 3'b000;
            alu_control    <= '0;
            imm_src        <= 4'b0000;
            result_src     <= 2'b00;
            mc_start       <= 1'b0;
            mc_op          <= 3'b000;
            illegal_instr  <= 1'b0;
        end else begin
            ctrl_valid     <= w_d_valid;
            reg_write      <= w_d_rw;
            mem_write      <= w_d_mw;
            jump           <= w_d_j;
            jump_cond      <= w_d_jc;
            alu_src_op1    <= w_d_s1;
            alu_src_op2    <= w_d_s2;
            pc_target_src  <= w_d_pts;
            jump_cond_type <= w_d_jct;
            alu_control    <= w_d_alu;
            imm_src        <= w_d_imm;
            result_src     <= w_d_res;
            mc_start       <= w_start;
            mc_op          <= w_d_mc_op;
            illegal_instr  <= w_trap;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - randomized and directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
    localparam int MCL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, ex_load, redirect;
    logic [2:0]  op, func3;
    logic [10:0] func11;
    logic [4:0]  rs1, rs2, rd, ex_rd;
    logic        ctrl_valid, reg_write, mem_write, jump, jump_cond;
    logic        alu_src_op1, alu_src_op2, pc_target_src, mc_start, stall, illegal_instr;
    logic [2:0]  jump_cond_type, mc_op;
    logic [3:0]  alu_control, imm_src;
    logic [1:0]  result_src;

    int checks = 0;
    int errors = 0;
    int busy_left = 0;
    logic [25:0] exp_q = '0;

    pipe_ctrl_unit #(.REG_AW(5), .MC_LATENCY(MCL), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .op(op), .func3(func3),
        .func11(func11), .rs1(rs1), .rs2(rs2), .rd(rd), .ex_load(ex_load), .ex_rd(ex_rd),
        .redirect(redirect), .ctrl_valid(ctrl_valid), .reg_write(reg_write),
        .mem_write(mem_write), .jump(jump), .jump_cond(jump_cond), .alu_src_op1(alu_src_op1),
        .alu_src_op2(alu_src_op2), .pc_target_src(pc_target_src),
        .jump_cond_type(jump_cond_type), .alu_control(alu_control), .imm_src(imm_src),
        .result_src(result_src), .mc_start(mc_start), .mc_op(mc_op), .stall(stall),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] dut_q();
        return {ctrl_valid, reg_write, mem_write, jump, jump_cond, alu_src_op1, alu_src_op2,
                pc_target_src, jump_cond_type, alu_control, imm_src, result_src, mc_start,
                mc_op, illegal_instr};
    endfunction

    function automatic logic hazard();
        return instr_valid && ex_load && ex_rd != 0 &&
               (ex_rd == rs1 || (ex_rd == rs2 && (op == 0 || op == 2 || op == 6)));
    endfunction

    function automatic logic illegal_enc();
`ifdef CTRL_ILLEGAL_TRAP_EN
        return op == 7 || (op == 3 && func3 > 2) || (op == 5 && func3 != 0 && func3 != 2);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_stall();
        return rst_n && !redirect && (busy_left > 0 || hazard());
    endfunction

    // Reference: what the ID/EX slot should hold after the next clock edge
    function automatic logic [25:0] model_q();
        logic cv, rw, mw, j, jc, s1, s2, pts, mcs, ill;
        logic [3:0] alu, imm;
        logic [1:0] res;
        logic [2:0] mco;
        if (redirect || busy_left > 0 || !instr_valid || hazard()) return '0;
        if (illegal_enc()) return 26'd1;
        rw = op[1:0] != 2'b10;
        mw = op == 2;
        j = (op == 3 || op == 5) && func3 == 2;
        jc = op == 6;
        s1 = op != 3;
        s2 = !(op == 0 || op == 6);
        pts = op == 5;
        alu = 0; imm = 0; res = 0;
        if (op == 0) alu = {func11[0], func3};
        if (op == 1) alu = {1'b0, func3};
        if (op == 6) alu = 1;
        if (op == 4) alu = {1'b1, func3};
        if (op == 1 && (func3 == 5 || func3 == 6)) imm = 4'b0001;
        if (op == 2) imm = 4'b0100;
        if (op == 3) imm = (func3 == 1) ? 4'b1110 : 4'b1100;
        if (op == 6) imm = 4'b1000;
        if (op == 3 && func3 == 2) res = 2'b10;
        if (op == 5 && func3 == 0) res = 2'b01;
        cv = op != 4;
        mcs = op == 4;
        mco = mcs ? func3 : 3'b000;
        ill = 1'b0;
        return {cv, rw, mw, j, jc, s1, s2, pts, func3, alu, imm, res, mcs, mco, ill};
    endfunction

    task automatic tick();
        int nb;
        exp_q = model_q();
        if (redirect) nb = 0;
        else if (busy_left > 0) nb = busy_left - 1;
        else if (instr_valid && op == 4 && !hazard()) nb = MCL;
        else nb = 0;
        @(posedge clk);
        busy_left = nb;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_valid = 0; op = 0; func3 = 0; func11 = 0; rs1 = 0; rs2 = 0; rd = 0;
        ex_load = 0; ex_rd = 0; redirect = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        instr_valid = 1; ex_load = 1; ex_rd = 3; rs1 = 3;
        rst_n = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (dut_q() !== 26'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", dut_q()); end
        @(negedge clk); @(negedge clk);
        idle_inputs();
        rst_n = 1;
        busy_left = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got %b want 0", stall); end
        @(negedge clk);
    endtask

    task automatic test_alu_a();
        idle_inputs();
        instr_valid = 1; op = 0; func3 = 3'b011; func11 = 11'h001; rs1 = 1; rs2 = 2; rd = 4;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_a_stall got %b want 0", stall); end
        tick();
        checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL alu_a_valid got %b want 1", ctrl_valid); end
        checks++; if (alu_control !== 4'b1011) begin errors++; $display("FAIL alu_a_ctrl got %b want 1011", alu_control); end
        checks++; if (reg_write !== 1'b1 || result_src !== 2'b00) begin errors++; $display("FAIL alu_a_rw_res got %b/%b want 1/00", reg_write, result_src); end
        checks++; if (dut_q() !== exp_q) begin errors++; $display("FAIL alu_a_all got %h want %h", dut_q(), exp_q); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        instr_valid = 1; op = 2; func3 = 0; ex_load = 1; ex_rd = 5; rs1 = 1; rs2 = 5;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
        tick();
        checks++; if (ctrl_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b want 0", ctrl_valid); end
        ex_load = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b want 0", stall); end
        tick();
        checks++; if (ctrl_valid !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL lu_issue got %b/%b want 1/1", ctrl_valid, mem_write); end
    endtask

    task automatic test_multicycle();
        int n;
        idle_inputs();
        instr_valid = 1; op = 4; func3 = 3'b010; rs1 = 1; rs2 = 2;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mc_first_stall got %b want 0", stall); end
        tick();
        checks++; if (mc_start !== 1'b1 || mc_op !== 3'b010) begin errors++; $display("FAIL mc_start got %b/%b want 1/010", mc_start, mc_op); end
        checks++; if (dut_q() !== exp_q) begin errors++; $display("FAIL mc_slot got %h want %h", dut_q(), exp_q); end
        op = 1; func3 = 3'b101;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (stall !== 1'b1) break;
            n++;
            tick();
            if (mc_start !== 1'b0 || ctrl_valid !== 1'b0) begin
                errors++; $display("FAIL mc_busy_bubble got %b/%b want 0/0", mc_start, ctrl_valid);
            end
        end
        checks++; if (n != MCL) begin errors++; $display("FAIL mc_stall_len got %0d want %0d", n, MCL); end
        tick();
        checks++; if (ctrl_valid !== 1'b1 || imm_src !== 4'b0001) begin errors++; $display("FAIL mc_next_issue got %b/%b want 1/0001", ctrl_valid, imm_src); end
    endtask

    task automatic test_redirect();
        idle_inputs();
        instr_valid = 1; op = 3; func3 = 3'b010; redirect = 1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_stall got %b want 0", stall); end
        tick();
        checks++; if (ctrl_valid !== 1'b0 || jump !== 1'b0) begin errors++; $display("FAIL rd_flush got %b/%b want 0/0", ctrl_valid, jump); end
        redirect = 0; op = 4; func3 = 3'b001;
        tick();
        checks++; if (mc_start !== 1'b1) begin errors++; $display("FAIL rd_mc_start got %b want 1", mc_start); end
        op = 0;
        tick();
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rd_busy_stall got %b want 1", stall); end
        redirect = 1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_busy_drop got %b want 0", stall); end
        tick();
        redirect = 0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rd_idle got %b want 0", stall); end
        tick();
        checks++; if (ctrl_valid !== 1'b1) begin errors++; $display("FAIL rd_resume got %b want 1", ctrl_valid); end
    endtask

    task automatic test_illegal();
        logic want_ill, want_cv;
`ifdef CTRL_ILLEGAL_TRAP_EN
        want_ill = 1'b1; want_cv = 1'b0;
`else
        want_ill = 1'b0; want_cv = 1'b1;
`endif
        idle_inputs();
        instr_valid = 1; op = 7; func3 = 3'($urandom_range(0, 7));
        tick();
        checks++; if (illegal_instr !== want_ill || ctrl_valid !== want_cv) begin errors++; $display("FAIL ill_h got %b/%b want %b/%b", illegal_instr, ctrl_valid, want_ill, want_cv); end
        op = 0;
        tick();
        checks++; if (illegal_instr !== 1'b0) begin errors++; $display("FAIL ill_pulse got %b want 0", illegal_instr); end
    endtask

    task automatic test_reset_mid_busy();
        idle_inputs();
        instr_valid = 1; op = 4; func3 = 3'b111;
        tick();
        op = 0;
        tick();
        #2;
        rst_n = 0;
        #1;
        checks++; if (dut_q() !== 26'd0 || stall !== 1'b0) begin errors++; $display("FAIL rst_busy got %h/%b want 0/0", dut_q(), stall); end
        busy_left = 0;
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_busy_release got %b want 0", stall); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            instr_valid = ($urandom_range(0, 9) < 8);
            op = 3'($urandom_range(0, 7));
            func3 = 3'($urandom_range(0, 7));
            func11 = 11'($urandom);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rd = 5'($urandom);
            ex_load = ($urandom_range(0, 9) < 3);
            ex_rd = 5'($urandom_range(0, 3));
            redirect = ($urandom_range(0, 19) == 0);
            #1;
            checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall[%0d] got %b want %b", i, stall, exp_stall()); end
            tick();
            checks++; if (dut_q() !== exp_q) begin errors++; $display("FAIL rnd_q[%0d] got %h want %h", i, dut_q(), exp_q); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_a();
        test_load_use();
        test_multicycle();
        test_redirect();
        test_illegal();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
